// File: rtl/sram_wb_pkg.sv
// Shared types and elaboration helpers for the Wishbone-to-8-bit-SRAM bridge.
package sram_wb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_RECOVER,
        S_ACK
    } state_t;

    // Smallest legal strobe length; the top clamps WAIT to this.
    localparam int WAIT_MIN = 1;

    function automatic int wb_bytes(input int dw);
        return dw / 8;
    endfunction

    function automatic int lane_w(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/sram_byte_phy.sv
// Single-byte SRAM access engine: ADDR (1) -> STROBE (WAIT) -> RECOVER (1).
// A start seen during RECOVER chains straight into the next ADDR with no gap.
module sram_byte_phy
    import sram_wb_pkg::*;
#(
    parameter int RAM_AW = 18,
    parameter int WAIT   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_addr,
    input  logic [7:0]        i_wdat,
    output logic              o_done,
    output logic [7:0]        o_rdat,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_ce,
    output logic              o_ram_oe,
    output logic              o_ram_we,
    output logic [7:0]        o_ram_dat,
    output logic              o_ram_dat_oe,
    input  logic [7:0]        i_ram_dat
);

    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_we_op;
    logic [7:0]        r_rdat;
    logic [RAM_AW-1:0] r_ram_addr;
    logic              r_ram_ce;
    logic              r_ram_oe;
    logic              r_ram_we;
    logic [7:0]        r_ram_dat;
    logic              r_ram_dat_oe;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we_op      <= 1'b0;
            r_rdat       <= '0;
            r_ram_addr   <= '0;
            r_ram_ce     <= 1'b0;
            r_ram_oe     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_dat    <= '0;
            r_ram_dat_oe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RECOVER: begin
                    if (i_start) begin
                        r_state      <= S_ADDR;
                        r_we_op      <= i_we;
                        r_ram_addr   <= i_addr;
                        r_ram_ce     <= 1'b1;
                        r_ram_dat    <= i_we ? i_wdat : 8'h00;
                        r_ram_dat_oe <= i_we;
                    end else begin
                        r_state      <= S_IDLE;
                        r_ram_addr   <= '0;
                        r_ram_ce     <= 1'b0;
                        r_ram_dat    <= '0;
                        r_ram_dat_oe <= 1'b0;
                    end
                end
                S_ADDR: begin
                    r_state  <= S_STROBE;
                    r_cnt    <= CW'(WAIT - 1);
                    r_ram_oe <= ~r_we_op;
                    r_ram_we <= r_we_op;
                end
                S_STROBE: begin
                    if (r_cnt == '0) begin
                        // Write data and address stay up through RECOVER for hold time.
                        r_state  <= S_RECOVER;
                        r_ram_oe <= 1'b0;
                        r_ram_we <= 1'b0;
                        if (!r_we_op)
                            r_rdat <= i_ram_dat;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_done       = (r_state == S_RECOVER);
    assign o_rdat       = r_rdat;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_ce     = r_ram_ce;
    assign o_ram_oe     = r_ram_oe;
    assign o_ram_we     = r_ram_we;
    assign o_ram_dat    = r_ram_dat;
    assign o_ram_dat_oe = r_ram_dat_oe;

endmodule

// File: rtl/sram_wb_bridge.sv
// Wishbone-classic slave splitting each bus word into per-byte SRAM accesses.
// States: IDLE | wait for cyc&stb ; ADDR | selected lanes running in the phy ; ACK | one-cycle ack
module sram_wb_bridge
    import sram_wb_pkg::*;
#(
    parameter int WB_DW  = 8,
    parameter int WB_AW  = 24,
    parameter int RAM_AW = 18,
    parameter int WAIT   = 2
) (
    input  logic               i_wb_clk,
    input  logic               i_wb_rst,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [WB_AW-1:0]   i_wb_addr,
    input  logic [WB_DW/8-1:0] i_wb_sel,
    input  logic [WB_DW-1:0]   i_wb_dat,
    output logic [WB_DW-1:0]   o_wb_dat,
    output logic               o_wb_ack,
    output logic [RAM_AW-1:0]  o_ram_addr,
    output logic               o_ram_ce,
    output logic               o_ram_oe,
    output logic               o_ram_we,
    output logic [7:0]         o_ram_dat,
    output logic               o_ram_dat_oe,
    input  logic [7:0]         i_ram_dat
);

    localparam int BYTES    = wb_bytes(WB_DW);
    localparam int LW       = lane_w(BYTES);
    localparam int SH       = $clog2(BYTES);
    localparam int WAIT_EFF = (WAIT < WAIT_MIN) ? WAIT_MIN : WAIT;

    function automatic logic [LW-1:0] f_low(input logic [BYTES-1:0] m);
        f_low = '0;
        for (int i = BYTES - 1; i >= 0; i--)
            if (m[i])
                f_low = LW'(i);
    endfunction

    function automatic logic [BYTES-1:0] f_mask(input logic [LW-1:0] lane);
        return BYTES'(1) << lane;
    endfunction

    state_t             r_state;
    logic               r_we;
    logic [WB_AW-1:0]   r_addr;
    logic [WB_DW-1:0]   r_dat;
    logic [BYTES-1:0]   r_pending;
    logic [LW-1:0]      r_lane;
    logic               r_abort;
    logic [WB_DW-1:0]   r_buf;
    logic               r_ack;
    logic [WB_DW-1:0]   r_wb_dat;

    logic               w_req;
    logic               w_more;
    logic               w_start;
    logic               w_phy_done;
    logic [7:0]         w_phy_rdat;
    logic [LW-1:0]      w_first_lane;
    logic [LW-1:0]      w_next_lane;
    logic [LW-1:0]      w_st_lane;
    logic [WB_AW-1:0]   w_src_addr;
    logic [WB_DW-1:0]   w_src_dat;
    logic               w_st_we;
    logic [RAM_AW-1:0]  w_st_addr;
    logic [7:0]         w_st_wdat;
    logic [WB_DW-1:0]   w_buf_next;

    assign w_req        = (r_state == S_IDLE) & i_wb_cyc & i_wb_stb;
    assign w_first_lane = f_low(i_wb_sel);
    assign w_next_lane  = f_low(r_pending);
    assign w_more       = (r_state == S_ADDR) & w_phy_done & ~r_abort & i_wb_cyc & (|r_pending);
    assign w_start      = (w_req & (|i_wb_sel)) | w_more;

    // First lane comes straight from the bus so ADDR starts one cycle after the request.
    always_comb begin
        w_st_lane  = w_next_lane;
        w_src_addr = r_addr;
        w_src_dat  = r_dat;
        w_st_we    = r_we;
        if (r_state == S_IDLE) begin
            w_st_lane  = w_first_lane;
            w_src_addr = i_wb_addr;
            w_src_dat  = i_wb_dat;
            w_st_we    = i_wb_we;
        end
        w_st_addr = (RAM_AW'(w_src_addr) << SH) | RAM_AW'(w_st_lane);
        w_st_wdat = w_src_dat[8*int'(w_st_lane) +: 8];
    end

    always_comb begin
        w_buf_next = r_buf;
        if (!r_we)
            w_buf_next[8*int'(r_lane) +: 8] = w_phy_rdat;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_dat     <= '0;
            r_pending <= '0;
            r_lane    <= '0;
            r_abort   <= 1'b0;
            r_buf     <= '0;
            r_ack     <= 1'b0;
            r_wb_dat  <= '0;
        end else begin
            r_ack    <= 1'b0;
            r_wb_dat <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_we      <= i_wb_we;
                        r_addr    <= i_wb_addr;
                        r_dat     <= i_wb_dat;
                        r_buf     <= '0;
                        r_abort   <= 1'b0;
                        r_lane    <= w_first_lane;
                        r_pending <= i_wb_sel & ~f_mask(w_first_lane);
                        if (i_wb_sel == '0) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (!i_wb_cyc)
                        r_abort <= 1'b1;
                    if (w_phy_done) begin
                        r_buf <= w_buf_next;
                        // An abort lets the running byte finish but starts no further lanes.
                        if (r_abort || !i_wb_cyc) begin
                            r_state <= S_IDLE;
                        end else if (|r_pending) begin
                            r_lane    <= w_next_lane;
                            r_pending <= r_pending & ~f_mask(w_next_lane);
                        end else begin
                            r_state  <= S_ACK;
                            r_ack    <= 1'b1;
                            r_wb_dat <= w_buf_next;
                        end
                    end
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    sram_byte_phy #(
        .RAM_AW (RAM_AW),
        .WAIT   (WAIT_EFF)
    ) u_phy (
        .i_clk        (i_wb_clk),
        .i_rst        (i_wb_rst),
        .i_start      (w_start),
        .i_we         (w_st_we),
        .i_addr       (w_st_addr),
        .i_wdat       (w_st_wdat),
        .o_done       (w_phy_done),
        .o_rdat       (w_phy_rdat),
        .o_ram_addr   (o_ram_addr),
        .o_ram_ce     (o_ram_ce),
        .o_ram_oe     (o_ram_oe),
        .o_ram_we     (o_ram_we),
        .o_ram_dat    (o_ram_dat),
        .o_ram_dat_oe (o_ram_dat_oe),
        .i_ram_dat    (i_ram_dat)
    );

    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_wb_dat;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Randomised bench for sram_wb_bridge (32-bit bus, WAIT=2) against a byte-array reference model.
module tb_sram_wb_bridge;

    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [23:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic [11:0] o_ram_addr;
    logic        o_ram_ce, o_ram_oe, o_ram_we, o_ram_dat_oe;
    logic [7:0]  o_ram_dat;
    logic [7:0]  ram_rd;

    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];

    int n_cmp = 0;
    int n_mis = 0;
    int ce_cyc = 0;
    int we_cyc = 0;
    int bad = 0;
    int viol = 0;
    logic [11:0] cur_base = '0;
    logic [3:0]  cur_sel = '0;

    always #5 clk = ~clk;

    sram_wb_bridge #(
        .WB_DW (32), .WB_AW (24), .RAM_AW (12), .WAIT (WAITC)
    ) dut (
        .i_wb_clk     (clk),
        .i_wb_rst     (rst),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (wb_we),
        .i_wb_addr    (addr),
        .i_wb_sel     (sel),
        .i_wb_dat     (wdat),
        .o_wb_dat     (o_wb_dat),
        .o_wb_ack     (o_wb_ack),
        .o_ram_addr   (o_ram_addr),
        .o_ram_ce     (o_ram_ce),
        .o_ram_oe     (o_ram_oe),
        .o_ram_we     (o_ram_we),
        .o_ram_dat    (o_ram_dat),
        .o_ram_dat_oe (o_ram_dat_oe),
        .i_ram_dat    (ram_rd)
    );

    // Asynchronous SRAM: reads drive only while ce&oe, otherwise junk.
    assign ram_rd = (o_ram_ce && o_ram_oe) ? mem[o_ram_addr] : 8'hEE;

    always @(negedge clk) begin
        if (o_ram_ce) ce_cyc++;
        if (o_ram_we) we_cyc++;
        if (o_ram_oe && o_ram_dat_oe) viol++;
        if (o_ram_we && !o_ram_dat_oe) viol++;
        if ((o_ram_oe || o_ram_we) &&
            (((o_ram_addr & 12'hFFC) != cur_base) || !cur_sel[o_ram_addr[1:0]]))
            bad++;
        if (o_ram_ce && o_ram_we) mem[o_ram_addr] = o_ram_dat;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input logic we, input logic [23:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        @(negedge clk);
        ce_cyc = 0; we_cyc = 0; bad = 0;
        cur_base = {a[9:0], 2'b00};
        cur_sel  = s;
        cyc = 1'b1; stb = 1'b1; wb_we = we; addr = a; sel = s; wdat = d;
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (o_wb_ack) begin
                lat = c;
                rd  = o_wb_dat;
                break;
            end
            if (c == 1) begin
                addr = 24'($urandom); wdat = $urandom; sel = 4'($urandom); wb_we = 1'($urandom);
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic run_chk(input string tag, input logic we, input logic [23:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd, exp;
        int lat, n;
        n   = $countones(s);
        exp = '0;
        for (int l = 0; l < 4; l++)
            if (s[l]) exp[8*l +: 8] = ref_mem[{a[9:0], 2'(l)}];
        do_txn(we, a, s, d, rd, lat);
        chk({tag, ":lat"}, lat, 1 + n * (2 + WAITC));
        if (!we) chk({tag, ":rdat"}, rd, exp);
        chk({tag, ":ce_cycles"}, ce_cyc, n * (2 + WAITC));
        chk({tag, ":we_cycles"}, we_cyc, we ? n * WAITC : 0);
        chk({tag, ":stray_addr"}, bad, 0);
        if (we)
            for (int l = 0; l < 4; l++)
                if (s[l]) ref_mem[{a[9:0], 2'(l)}] = d[8*l +: 8];
    endtask

    initial begin
        int acks;
        logic [31:0] d;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        repeat (3) @(negedge clk);
        chk("rst:strobes", {31'b0, o_ram_ce | o_ram_oe | o_ram_we | o_ram_dat_oe}, 0);
        chk("rst:ack", {31'b0, o_wb_ack}, 0);
        chk("rst:addr", {20'b0, o_ram_addr}, 0);
        chk("rst:wb_dat", o_wb_dat, 0);
        rst = 1'b0;

        run_chk("w32", 1'b1, 24'h4, 4'hF, 32'h11223344);
        chk("mem10", {mem[12'h10], mem[12'h11], mem[12'h12], mem[12'h13]}, 32'h44332211);
        run_chk("r32", 1'b0, 24'h4, 4'hF, 32'h0);
        run_chk("wAA", 1'b1, 24'h4, 4'hF, 32'hDDCCBBAA);
        run_chk("r_sel5", 1'b0, 24'h4, 4'h5, 32'h0);
        run_chk("w_sel0", 1'b1, 24'h4, 4'h0, 32'hFFFFFFFF);
        run_chk("r_sel0", 1'b0, 24'h4, 4'h0, 32'h0);

        for (int t = 0; t < 40; t++)
            run_chk($sformatf("rnd%0d", t), 1'($urandom), 24'($urandom_range(0, 15)),
                    4'($urandom), $urandom);

        // Abort: cyc dropped in the first STROBE cycle of lane 1 of a 4-lane write.
        @(negedge clk);
        ce_cyc = 0; we_cyc = 0; bad = 0; acks = 0;
        cur_base = 12'h020; cur_sel = 4'hF;
        d = $urandom;
        cyc = 1'b1; stb = 1'b1; wb_we = 1'b1; addr = 24'h8; sel = 4'hF; wdat = d;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (o_wb_ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (o_wb_ack) acks++;
        end
        ref_mem[12'h20] = d[7:0];
        ref_mem[12'h21] = d[15:8];
        chk("abort:ack", acks, 0);
        chk("abort:ce_cycles", ce_cyc, 2 * (2 + WAITC));
        chk("abort:we_cycles", we_cyc, 2 * WAITC);
        chk("abort:stray_addr", bad, 0);
        chk("abort:mem", {mem[12'h23], mem[12'h22], mem[12'h21], mem[12'h20]},
            {ref_mem[12'h23], ref_mem[12'h22], ref_mem[12'h21], ref_mem[12'h20]});
        chk("abort:idle_ce", {31'b0, o_ram_ce}, 0);
        run_chk("abort:next", 1'b0, 24'h8, 4'hF, 32'h0);

        // Asynchronous reset in the middle of a write strobe.
        @(negedge clk);
        cur_base = 12'h190; cur_sel = 4'hF;
        cyc = 1'b1; stb = 1'b1; wb_we = 1'b1; addr = 24'd100; sel = 4'hF; wdat = $urandom;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid:we_before_rst", {31'b0, o_ram_we}, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid:strobes", {28'b0, o_ram_ce, o_ram_oe, o_ram_we, o_ram_dat_oe}, 0);
        chk("mid:ack_addr", {19'b0, o_wb_ack, o_ram_addr}, 0);
        chk("mid:wb_dat", o_wb_dat, 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_chk("post_rst:w", 1'b1, 24'h5, 4'hF, $urandom);
        run_chk("post_rst:r", 1'b0, 24'h5, 4'hF, 32'h0);

        chk("oe_vs_dat_oe", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
